// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the pipeline sequencer
//
// Purpose: memory-wait FSM state encoding, register-index width and the
//          zero-register constant used by the hazard equations.
// Ports:   none (package).
package cpu_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_stall_mem_fsm.sv
// rtl/hazard_stall_mem_fsm.sv - data-memory wait sequencer with timeout
//
// Purpose: tracks an outstanding data-memory access, requests the pipeline
//          freeze while it waits, abandons it after TIMEOUT wait cycles and
//          raises a sticky error flag when that happens.
// Ports:   clk_i, rst_i     clock, synchronous active-high reset
//          memop_i          load or store present in MEM
//          mem_ack_i        memory completes the access this cycle
//          mem_req_o        data-memory request (0 while in reset)
//          freeze_o         hold the whole pipeline this cycle
//          err_o            sticky timeout flag
module hazard_stall_mem_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic memop_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic freeze_o,
    output logic err_o
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_o;
        mem_req_o  = 1'b0;
        freeze_o   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                RUN: begin
                    mem_req_o = memop_i;
                    // A same-cycle ack is a zero-wait access: never leave RUN.
                    if (memop_i && !mem_ack_i) begin
                        freeze_o   = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        // Give up on the access and let the pipeline move on.
                        err_d      = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        freeze_o   = 1'b1;
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - 5-stage pipeline stall/flush/bubble sequencer
//
// Purpose: merges memory-wait freeze, load-use stall and ID-stage redirect
//          into the pipeline-register controls, and counts stalled cycles.
// Ports:   clk_i, rst_i               clock, synchronous active-high reset
//          EX_MEM_MemRead_i/Write_i   load/store in MEM
//          mem_ack_i / mem_req_o      data-memory handshake
//          ID_EX_MemRead_i, ID_EX_Rt_i, IF_ID_Rs_i, IF_ID_Rt_i  load-use inputs
//          Branch_taken_i, Jump_i     control-flow redirect from ID
//          PC_en_o, IF_ID_en_o, IF_ID_flush_o, ID_EX_en_o, ID_EX_bubble_o,
//          EX_MEM_en_o, MEM_WB_bubble_o  pipeline-register controls
//          stall_cnt_o                saturating stalled-cycle count
//          err_o                      sticky memory-timeout flag
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             EX_MEM_MemRead_i,
    input  logic             EX_MEM_MemWrite_i,
    input  logic             mem_ack_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [REG_W-1:0] ID_EX_Rt_i,
    input  logic [REG_W-1:0] IF_ID_Rs_i,
    input  logic [REG_W-1:0] IF_ID_Rt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    output logic             mem_req_o,
    output logic             PC_en_o,
    output logic             IF_ID_en_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_en_o,
    output logic             ID_EX_bubble_o,
    output logic             EX_MEM_en_o,
    output logic             MEM_WB_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    logic memop;
    logic freeze;
    logic luse;
    logic redirect;

    assign memop    = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;
    assign luse     = ID_EX_MemRead_i && (ID_EX_Rt_i != REG_ZERO) &&
                      ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));
    assign redirect = Branch_taken_i | Jump_i;

    hazard_stall_mem_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .memop_i   (memop),
        .mem_ack_i (mem_ack_i),
        .mem_req_o (mem_req_o),
        .freeze_o  (freeze),
        .err_o     (err_o)
    );

    always_comb begin
        PC_en_o         = 1'b1;
        IF_ID_en_o      = 1'b1;
        IF_ID_flush_o   = 1'b0;
        ID_EX_en_o      = 1'b1;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_en_o     = 1'b1;
        MEM_WB_bubble_o = 1'b0;
        if (rst_i) begin
            PC_en_o         = 1'b0;
            IF_ID_en_o      = 1'b0;
            IF_ID_flush_o   = 1'b1;
            ID_EX_en_o      = 1'b0;
            ID_EX_bubble_o  = 1'b1;
            EX_MEM_en_o     = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (freeze) begin
            // MEM_WB bubble lets the older instruction retire exactly once.
            PC_en_o         = 1'b0;
            IF_ID_en_o      = 1'b0;
            ID_EX_en_o      = 1'b0;
            EX_MEM_en_o     = 1'b0;
            MEM_WB_bubble_o = 1'b1;
        end else if (luse) begin
            // A coincident redirect is dropped; the branch re-resolves next cycle.
            PC_en_o        = 1'b0;
            IF_ID_en_o     = 1'b0;
            ID_EX_bubble_o = 1'b1;
        end else if (redirect) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if ((freeze || luse) && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int T_TIMEOUT = 4;
    localparam int CNT_W_A   = 16;
    localparam int CNT_W_B   = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ex_rd, ex_wr, ack, id_rd, br, jmp;
    logic [4:0] id_rt, if_rs, if_rt;

    logic       req_a, pc_a, ifen_a, fl_a, iden_a, bub_a, exen_a, wbb_a, err_a;
    logic       req_b, pc_b, ifen_b, fl_b, iden_b, bub_b, exen_b, wbb_b, err_b;
    logic [CNT_W_A-1:0] cnt_a;
    logic [CNT_W_B-1:0] cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl #(.TIMEOUT(T_TIMEOUT), .CNT_W(CNT_W_A)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .EX_MEM_MemRead_i(ex_rd), .EX_MEM_MemWrite_i(ex_wr), .mem_ack_i(ack),
        .ID_EX_MemRead_i(id_rd), .ID_EX_Rt_i(id_rt), .IF_ID_Rs_i(if_rs), .IF_ID_Rt_i(if_rt),
        .Branch_taken_i(br), .Jump_i(jmp),
        .mem_req_o(req_a), .PC_en_o(pc_a), .IF_ID_en_o(ifen_a), .IF_ID_flush_o(fl_a),
        .ID_EX_en_o(iden_a), .ID_EX_bubble_o(bub_a), .EX_MEM_en_o(exen_a),
        .MEM_WB_bubble_o(wbb_a), .stall_cnt_o(cnt_a), .err_o(err_a)
    );

    hazard_stall_ctrl #(.TIMEOUT(T_TIMEOUT), .CNT_W(CNT_W_B)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .EX_MEM_MemRead_i(ex_rd), .EX_MEM_MemWrite_i(ex_wr), .mem_ack_i(ack),
        .ID_EX_MemRead_i(id_rd), .ID_EX_Rt_i(id_rt), .IF_ID_Rs_i(if_rs), .IF_ID_Rt_i(if_rt),
        .Branch_taken_i(br), .Jump_i(jmp),
        .mem_req_o(req_b), .PC_en_o(pc_b), .IF_ID_en_o(ifen_b), .IF_ID_flush_o(fl_b),
        .ID_EX_en_o(iden_b), .ID_EX_bubble_o(bub_b), .EX_MEM_en_o(exen_b),
        .MEM_WB_bubble_o(wbb_b), .stall_cnt_o(cnt_b), .err_o(err_b)
    );

    // {mem_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_bubble, EX_MEM_en, MEM_WB_bubble}
    wire [7:0] ctrl_a = {req_a, pc_a, ifen_a, fl_a, iden_a, bub_a, exen_a, wbb_a};
    wire [7:0] ctrl_b = {req_b, pc_b, ifen_b, fl_b, iden_b, bub_b, exen_b, wbb_b};

    localparam logic [7:0] C_RESET  = 8'b0001_0101;
    localparam logic [7:0] C_IDLE   = 8'b0110_1010;
    localparam logic [7:0] C_REQ    = 8'b1110_1010;
    localparam logic [7:0] C_FREEZE = 8'b1000_0001;
    localparam logic [7:0] C_LUSE   = 8'b0000_1110;
    localparam logic [7:0] C_FLUSH  = 8'b0111_1010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding access tracked as busy + cycles waited.
    bit       m_valid = 0;
    bit       m_busy  = 0;
    bit       m_err   = 0;
    int       m_waited = 0;
    int       m_cnt    = 0;
    bit       e_req, e_frz, e_luse, e_redir, e_memop;
    logic [7:0] e_ctrl;
    int       max_b;

    always @(negedge clk_i) begin
        e_memop = ex_rd || ex_wr;
        e_luse  = id_rd && (id_rt != 0) && (id_rt == if_rs || id_rt == if_rt);
        e_redir = br || jmp;
        if (m_busy) begin
            e_req = 1;
            e_frz = !ack && (m_waited < T_TIMEOUT);
        end else begin
            e_req = e_memop;
            e_frz = e_memop && !ack;
        end
        if (rst_i) e_ctrl = C_RESET;
        else e_ctrl = {e_req, !(e_frz || e_luse), !(e_frz || e_luse),
                       !e_frz && !e_luse && e_redir, !e_frz,
                       !e_frz && e_luse, !e_frz, e_frz};
        chk("ctrl", 32'(ctrl_a), 32'(e_ctrl));
        chk("ctrl_sat", 32'(ctrl_b), 32'(e_ctrl));
        if (m_valid) begin
            max_b = (1 << CNT_W_B) - 1;
            chk("stall_cnt", 32'(cnt_a), 32'(m_cnt));
            chk("stall_cnt_sat", 32'(cnt_b), 32'((m_cnt > max_b) ? max_b : m_cnt));
            chk("err", 32'(err_a), 32'(m_err));
            chk("err_sat", 32'(err_b), 32'(m_err));
        end
        if (rst_i) begin
            m_valid = 1; m_busy = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (!m_busy) begin
                if (e_frz) begin m_busy = 1; m_waited = 1; end
            end else if (ack) begin
                m_busy = 0;
            end else if (m_waited == T_TIMEOUT) begin
                m_busy = 0; m_err = 1;
            end else begin
                m_waited++;
            end
            if (e_frz || e_luse) m_cnt++;
        end
    end

    task automatic set_in(input logic rd, input logic wr, input logic a, input logic ird,
                          input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                          input logic b, input logic j);
        ex_rd = rd; ex_wr = wr; ack = a; id_rd = ird;
        id_rt = rt; if_rs = rs; if_rt = rt2; br = b; jmp = j;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("rst_ctrl0", 32'(ctrl_a), 32'(C_RESET));
        @(negedge clk_i); chk("rst_ctrl1", 32'(ctrl_a), 32'(C_RESET));

        next_cycle(); rst_i = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rst_cnt", 32'(cnt_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("idle_ctrl", 32'(ctrl_a), 32'(C_IDLE));

        next_cycle(); set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("zero_wait", 32'(ctrl_a), 32'(C_REQ));

        next_cycle(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("zero_wait_cnt", 32'(cnt_a), 0);
        chk("wait1", 32'(ctrl_a), 32'(C_FREEZE));
        next_cycle(); set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i); chk("wait2_branch", 32'(ctrl_a), 32'(C_FREEZE));
        next_cycle(); set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("wait3", 32'(ctrl_a), 32'(C_FREEZE));
        next_cycle(); set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("wait_ack", 32'(ctrl_a), 32'(C_REQ));
        next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("wait_cnt3", 32'(cnt_a), 3);

        next_cycle(); set_in(0, 0, 0, 1, 5, 5, 9, 0, 0);
        @(negedge clk_i); chk("luse", 32'(ctrl_a), 32'(C_LUSE));
        next_cycle(); set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("luse_r0", 32'(ctrl_a), 32'(C_IDLE));
        chk("luse_cnt", 32'(cnt_a), 4);
        next_cycle(); set_in(0, 0, 0, 1, 7, 3, 7, 1, 0);
        @(negedge clk_i); chk("luse_branch", 32'(ctrl_a), 32'(C_LUSE));
        next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk_i); chk("jump", 32'(ctrl_a), 32'(C_FLUSH));
        chk("jump_cnt", 32'(cnt_a), 5);

        for (int i = 0; i < T_TIMEOUT; i++) begin
            next_cycle(); set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk_i); chk("timeout_freeze", 32'(ctrl_a), 32'(C_FREEZE));
        end
        next_cycle(); set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("timeout_release", 32'(ctrl_a), 32'(C_REQ));
        chk("timeout_err_pre", 32'(err_a), 0);
        next_cycle(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i); chk("timeout_err", 32'(err_a), 1);
        chk("timeout_cnt", 32'(cnt_a), 9);
        chk("sat_cnt", 32'(cnt_b), 7);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk_i); chk("err_sticky", 32'(err_a), 1);
        end
        next_cycle(); rst_i = 1'b1;
        next_cycle(); rst_i = 1'b0;
        @(negedge clk_i); chk("err_cleared", 32'(err_a), 0);
        chk("cnt_cleared", 32'(cnt_a), 0);

        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst_i = ($urandom_range(0, 79) == 0);
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

        next_cycle();
        @(negedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage CPU.
- Drives enable, flush and bubble controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB from three hazard sources:
  - variable-latency data-memory accesses, via a req/ack handshake;
  - load-use data hazards;
  - taken branches and jumps resolved in ID.
- Sits beside the pipeline registers. It holds no datapath state, only the sequencing FSM and counters.

Parameters:
- TIMEOUT, 16: maximum MEM_WAIT cycles before the access is abandoned.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- EX_MEM_MemRead_i  in  1  load is in the MEM stage.
- EX_MEM_MemWrite_i  in  1  store is in the MEM stage.
- mem_ack_i  in  1  data memory completes the access this cycle.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_Rt_i  in  5  destination register of the load in EX.
- IF_ID_Rs_i  in  5  rs of the instruction in ID.
- IF_ID_Rt_i  in  5  rt of the instruction in ID.
- Branch_taken_i  in  1  branch resolved taken in ID.
- Jump_i  in  1  jump decoded in ID.
- mem_req_o  out  1  data-memory request.
- PC_en_o  out  1  PC write enable.
- IF_ID_en_o  out  1  IF_ID load enable.
- IF_ID_flush_o  out  1  IF_ID loads a NOP.
- ID_EX_en_o  out  1  ID_EX load enable.
- ID_EX_bubble_o  out  1  ID_EX loads zero control (WB/M/EX).
- EX_MEM_en_o  out  1  EX_MEM load enable.
- MEM_WB_bubble_o  out  1  MEM_WB loads zero WB control.
- stall_cnt_o  out  CNT_W  total stalled cycles, saturating.
- err_o  out  1  sticky memory-timeout flag.

Behaviour:
- States: RUN, MEM_WAIT. Registers: state, wait_cnt (ceil(log2 TIMEOUT)+1 bits), stall_cnt_o, err_o.
- Reset (rst_i high at a clock edge):
  - state=RUN, wait_cnt=0, stall_cnt_o=0, err_o=0.
  - While rst_i is high, combinational outputs are forced: all enables 0, IF_ID_flush_o=1, ID_EX_bubble_o=1, MEM_WB_bubble_o=1, mem_req_o=0.
  - Reset mid-MEM_WAIT drops mem_req_o in the same cycle and aborts the access.
- memop = EX_MEM_MemRead_i | EX_MEM_MemWrite_i.
- freeze:
  - Definition: PC_en_o, IF_ID_en_o, ID_EX_en_o, EX_MEM_en_o all 0, and MEM_WB_bubble_o=1.
  - Effect: the older instruction in MEM_WB retires and no duplicate is written back.
- RUN:
  - memop=1: mem_req_o=1 combinationally.
    - mem_ack_i=1 in the same cycle: zero-wait access, no freeze, stay in RUN.
    - Otherwise: freeze, go to MEM_WAIT, wait_cnt=1.
  - memop=0: mem_req_o=0.
- MEM_WAIT:
  - mem_req_o=1.
  - mem_ack_i=1: no freeze this cycle (pipeline advances), go to RUN, wait_cnt=0.
  - No ack and wait_cnt==TIMEOUT: set err_o (sticky until reset), no freeze, go to RUN. The access is abandoned.
  - Otherwise: freeze, wait_cnt+1.
- A new memop arriving in EX_MEM immediately after release is a new access and starts a new request in RUN.
- Load-use:
  - luse = ID_EX_MemRead_i & (ID_EX_Rt_i != 0) & ((ID_EX_Rt_i == IF_ID_Rs_i) | (ID_EX_Rt_i == IF_ID_Rt_i)).
  - Response: PC_en_o=0, IF_ID_en_o=0, ID_EX_bubble_o=1.
  - EX_MEM_en_o=1 and MEM_WB normal. Exactly one bubble per hazard, because the inputs change once the load advances.
- Control flow:
  - redirect = Branch_taken_i | Jump_i.
  - Response: IF_ID_flush_o=1 (discard the wrong-path fetch). PC_en_o stays 1 so the target loads.
- Priority: memory freeze > load-use > redirect.
  - While frozen, luse and redirect outputs are suppressed and re-evaluated after release.
  - luse together with redirect: luse wins, no flush; the branch re-resolves next cycle.
- Defaults when no hazard: all enables 1, flush/bubble 0.
- stall_cnt_o increments by 1 on each freeze cycle or luse-stall cycle. It saturates at all-ones.
- Latency: all control outputs are combinational from state and inputs. State, counters and err_o update on posedge clk_i.

Decomposition:
- Shared package cpu_ctrl_pkg: state encoding (RUN=0, MEM_WAIT=1), register-index width 5, zero-register constant.
- Hazard equations are small and stay inline. One natural sub-module: hazard_stall_mem_fsm (states, wait_cnt, timeout, err_o). The top level merges its freeze output with luse, redirect and the counter.

Test Plan:
- Reset: hold rst_i 2 cycles while memop=1 -> mem_req_o=0, all enables 0, all bubbles/flush 1. After release: state RUN, stall_cnt_o=0, err_o=0.
- Zero-wait access: memop=1 with mem_ack_i=1 in the same cycle -> mem_req_o=1, no freeze, stall_cnt_o unchanged.
- 3-cycle wait: memop=1, ack arrives on the 4th cycle -> 3 freeze cycles (EX_MEM_en_o=0, MEM_WB_bubble_o=1). Released on the ack cycle, stall_cnt_o=3.
- Load-use:
  - ID_EX_MemRead_i=1, Rt=5, IF_ID_Rs=5 -> PC_en_o=0, IF_ID_en_o=0, ID_EX_bubble_o=1 for 1 cycle.
  - Same with Rt=0 -> no stall.
- Priority:
  - luse + Branch_taken_i -> no flush, stall only.
  - Branch_taken_i during MEM_WAIT -> no flush until release.
  - Jump_i alone -> IF_ID_flush_o=1, PC_en_o=1.
- Timeout: TIMEOUT=4, memop=1, never ack -> 4 freeze cycles, then release with err_o=1. err_o stays 1 until rst_i; rst_i clears it.
